// File: rtl/scale_pyramid_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// scale_pyramid_sequencer
//
// Sweeps an image pyramid from a single start request. For every scale level
// k it derives the scale s, the scaled image size (w, h), the inverse scale,
// the per-axis correction factors and the scaled detection window size, then
// offers the record on a valid/ready stream. The sweep stops when the scaled
// image can no longer hold the window or after MAX_SCALES records.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   start, abort       begin a sweep (IDLE only) / cancel a running sweep
//   base_width/height  full-resolution image size W, H
//   scale_factor       per-level factor f in Q.FRAC, 0 < f < ONE
//   win_size           base detection window size N
//   win_size_inv,
//   stages             latched at start and forwarded with every record
//   busy, done, error  status: running / end-of-sweep pulse / sticky bad start
//   scale_count        records accepted in the current or last sweep
//   out_valid/ready    record handshake
//   out_*              record fields, stable while out_valid is high
// ---------------------------------------------------------------------------
module scale_pyramid_sequencer #(
  parameter int FRAC        = 16,
  parameter int WORD        = 32,
  parameter int ROW_BITS    = 10,
  parameter int COL_BITS    = 10,
  parameter int WIN_BITS    = 16,
  parameter int MAX_SCALES  = 32,
  parameter int IDX_BITS    = $clog2(MAX_SCALES + 1),
  parameter int DIV_LATENCY = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [ROW_BITS-1:0] base_width,
  input  logic [COL_BITS-1:0] base_height,
  input  logic [WORD-1:0]     scale_factor,
  input  logic [WIN_BITS-1:0] win_size,
  input  logic [WORD-1:0]     win_size_inv,
  input  logic [7:0]          stages,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [IDX_BITS-1:0] scale_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_BITS-1:0] out_idx,
  output logic [WORD-1:0]     out_scale,
  output logic [ROW_BITS-1:0] out_width,
  output logic [COL_BITS-1:0] out_height,
  output logic [WORD-1:0]     out_scale_inv,
  output logic [WORD-1:0]     out_scale_x,
  output logic [WORD-1:0]     out_scale_y,
  output logic [WIN_BITS-1:0] out_true_win,
  output logic [WORD-1:0]     out_win_size_inv,
  output logic [7:0]          out_stages
);

  localparam int PW = 2 * WORD;
  localparam logic [WORD-1:0] ONE    = WORD'(1) << FRAC;
  localparam logic [PW-1:0]   ONE_SQ = PW'(1) << (2 * FRAC);

  // Three issue cycles are already spent before waiting, so only the
  // remainder of the divider latency is idled away in DIV_WAIT.
  localparam int WAIT_CYCLES = (DIV_LATENCY > 3) ? DIV_LATENCY - 3 : 0;
  localparam int WAIT_W      = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_MUL_S, S_MUL_W, S_MUL_H, S_CHECK,
    S_DIV_INV, S_DIV_X, S_DIV_Y, S_DIV_WAIT,
    S_RD_INV, S_RD_X, S_RD_Y, S_MUL_WIN, S_OUT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ROW_BITS-1:0] w_in_q, w_in_d;
  logic [COL_BITS-1:0] h_in_q, h_in_d;
  logic [WORD-1:0]     f_q, f_d;
  logic [WIN_BITS-1:0] n_q, n_d;
  logic [WORD-1:0]     winv_q, winv_d;
  logic [7:0]          stages_q, stages_d;

  logic [WORD-1:0]     s_q, s_d;
  logic [ROW_BITS-1:0] w_q, w_d;
  logic [COL_BITS-1:0] h_q, h_d;
  logic [WORD-1:0]     inv_q, inv_d;
  logic [WORD-1:0]     x_q, x_d;
  logic [WORD-1:0]     y_q, y_d;
  logic [WIN_BITS-1:0] tw_q, tw_d;
  logic [IDX_BITS-1:0] k_q, k_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                vld_q, vld_d;

  // Divider pipeline: each slot carries a tag telling which of inv/x/y the
  // quotient belongs to, so results are captured wherever they emerge.
  logic [DIV_LATENCY-1:0] dv_vld_q, dv_vld_d;
  logic [1:0]             dv_tag_q [DIV_LATENCY];
  logic [1:0]             dv_tag_d [DIV_LATENCY];
  logic [WORD-1:0]        dv_quo_q [DIV_LATENCY];
  logic [WORD-1:0]        dv_quo_d [DIV_LATENCY];

  logic [WORD-1:0] mul_a, mul_b;
  logic [PW-1:0]   prod, prod_shift, prod_rnd;

  logic            div_issue;
  logic [1:0]      div_tag;
  logic [PW-1:0]   div_num;
  logic [WORD-1:0] div_den;
  logic [PW-1:0]   div_full;
  logic            unused_bits;

  // Shared multiplier operand select; one product per multiply state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MUL_S:   begin mul_a = s_q;             mul_b = f_q;   end
      S_MUL_W:   begin mul_a = WORD'(w_in_q);   mul_b = s_q;   end
      S_MUL_H:   begin mul_a = WORD'(h_in_q);   mul_b = s_q;   end
      S_MUL_WIN: begin mul_a = WORD'(n_q);      mul_b = inv_q; end
      default:   ;
    endcase
  end

  assign prod       = PW'(mul_a) * PW'(mul_b);
  assign prod_shift = prod >> FRAC;
  assign prod_rnd   = prod_shift + PW'(prod[FRAC-1]);

  // Divider operand select for the three back-to-back issue states.
  always_comb begin
    div_issue = 1'b0;
    div_tag   = 2'd0;
    div_num   = '0;
    div_den   = '0;
    case (state_q)
      S_DIV_INV: begin
        div_issue = 1'b1; div_tag = 2'd0; div_num = ONE_SQ; div_den = s_q;
      end
      S_DIV_X: begin
        div_issue = 1'b1; div_tag = 2'd1;
        div_num = PW'(w_in_q) << FRAC; div_den = WORD'(w_q);
      end
      S_DIV_Y: begin
        div_issue = 1'b1; div_tag = 2'd2;
        div_num = PW'(h_in_q) << FRAC; div_den = WORD'(h_q);
      end
      default: ;
    endcase
  end

  // CHECK guarantees non-zero divisors; the guard only keeps idle cycles clean.
  assign div_full    = (div_den == '0) ? '1 : div_num / PW'(div_den);
  assign unused_bits = ^{prod_rnd, div_full};

  // Next-state and datapath update for the whole sweep.
  always_comb begin
    state_d  = state_q;
    w_in_d   = w_in_q;
    h_in_d   = h_in_q;
    f_d      = f_q;
    n_d      = n_q;
    winv_d   = winv_q;
    stages_d = stages_q;
    s_d      = s_q;
    w_d      = w_q;
    h_d      = h_q;
    inv_d    = inv_q;
    x_d      = x_q;
    y_d      = y_q;
    tw_d     = tw_q;
    k_d      = k_q;
    wait_d   = wait_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    vld_d    = vld_q;

    dv_vld_d[0] = div_issue;
    dv_tag_d[0] = div_tag;
    dv_quo_d[0] = div_full[WORD-1:0];
    for (int i = 1; i < DIV_LATENCY; i++) begin
      dv_vld_d[i] = dv_vld_q[i-1];
      dv_tag_d[i] = dv_tag_q[i-1];
      dv_quo_d[i] = dv_quo_q[i-1];
    end

    if (dv_vld_q[DIV_LATENCY-1]) begin
      case (dv_tag_q[DIV_LATENCY-1])
        2'd0:    inv_d = dv_quo_q[DIV_LATENCY-1];
        2'd1:    x_d   = dv_quo_q[DIV_LATENCY-1];
        default: y_d   = dv_quo_q[DIV_LATENCY-1];
      endcase
    end

    // Abort wins over everything, including a handshake in the same cycle,
    // and flushes quotients still travelling through the divider.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      vld_d    = 1'b0;
      dv_vld_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            w_in_d   = base_width;
            h_in_d   = base_height;
            f_d      = scale_factor;
            n_d      = win_size;
            winv_d   = win_size_inv;
            stages_d = stages;
            k_d      = '0;
            err_d    = 1'b0;
            busy_d   = 1'b1;
            if (scale_factor == '0 || scale_factor >= ONE || win_size == '0) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_MUL_S;
            end
          end
        end
        S_MUL_S: begin
          s_d     = (k_q == '0) ? ONE : prod_shift[WORD-1:0];
          state_d = S_MUL_W;
        end
        S_MUL_W: begin
          w_d     = prod_rnd[ROW_BITS-1:0];
          state_d = S_MUL_H;
        end
        S_MUL_H: begin
          h_d     = prod_rnd[COL_BITS-1:0];
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (WORD'(w_q) < WORD'(n_q) || WORD'(h_q) < WORD'(n_q) ||
              k_q == IDX_BITS'(MAX_SCALES)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV_INV;
          end
        end
        S_DIV_INV: state_d = S_DIV_X;
        S_DIV_X:   state_d = S_DIV_Y;
        S_DIV_Y: begin
          wait_d  = '0;
          state_d = (WAIT_CYCLES > 0) ? S_DIV_WAIT : S_RD_INV;
        end
        S_DIV_WAIT: begin
          if (wait_q == WAIT_LAST) state_d = S_RD_INV;
          else                     wait_d  = wait_q + WAIT_W'(1);
        end
        S_RD_INV: state_d = S_RD_X;
        S_RD_X:   state_d = S_RD_Y;
        S_RD_Y:   state_d = S_MUL_WIN;
        S_MUL_WIN: begin
          tw_d    = prod_rnd[WIN_BITS-1:0];
          vld_d   = 1'b1;
          state_d = S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            vld_d   = 1'b0;
            k_d     = k_q + IDX_BITS'(1);
            state_d = S_MUL_S;
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All state, including the registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      w_in_q   <= '0;
      h_in_q   <= '0;
      f_q      <= '0;
      n_q      <= '0;
      winv_q   <= '0;
      stages_q <= '0;
      s_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      inv_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      tw_q     <= '0;
      k_q      <= '0;
      wait_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      dv_vld_q <= '0;
      for (int i = 0; i < DIV_LATENCY; i++) begin
        dv_tag_q[i] <= '0;
        dv_quo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      w_in_q   <= w_in_d;
      h_in_q   <= h_in_d;
      f_q      <= f_d;
      n_q      <= n_d;
      winv_q   <= winv_d;
      stages_q <= stages_d;
      s_q      <= s_d;
      w_q      <= w_d;
      h_q      <= h_d;
      inv_q    <= inv_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tw_q     <= tw_d;
      k_q      <= k_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      dv_vld_q <= dv_vld_d;
      for (int i = 0; i < DIV_LATENCY; i++) begin
        dv_tag_q[i] <= dv_tag_d[i];
        dv_quo_q[i] <= dv_quo_d[i];
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = err_q;
  assign scale_count      = k_q;
  assign out_valid        = vld_q;
  assign out_idx          = k_q;
  assign out_scale        = s_q;
  assign out_width        = w_q;
  assign out_height       = h_q;
  assign out_scale_inv    = inv_q;
  assign out_scale_x      = x_q;
  assign out_scale_y      = y_q;
  assign out_true_win     = tw_q;
  assign out_win_size_inv = winv_q;
  assign out_stages       = stages_q;

endmodule
